offset_add_stage: RTL and testbench

- Streaming two-operand adder stage. Consumes operand beats over a valid/ready handshake and produces registered sums downstream.
- When a beat carries no second operand, the stage substitutes the compile-time default DEFAULT_B, the hardware form of a defaulted argument.
- Sits directly downstream of the operand-producing stage and feeds the result consumer.
- Two-deep registered pipeline with full backpressure; throughput 1 beat/cycle.

---
 rtl/offset_add_stage.sv | 135 +++++++++++++
 tb/tb_offset_add_stage.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/offset_add_stage.sv
`default_nettype none
// ============================================================================
//  Module   : offset_add_stage
//  Purpose  : Two-stage valid/ready adder. A missing b operand is replaced
//             by DEFAULT_B. Define OFFSET_ADD_STATS_EN to add result counters.
//  Revision : 1.0  initial release
// ============================================================================
module offset_add_stage #(
   parameter int W         = 8,
   parameter int DEFAULT_B = 10
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_a,
   input  logic [W-1:0] in_b,
   input  logic         in_b_present,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W:0]   out_sum,
   output logic         out_used_default
`ifdef OFFSET_ADD_STATS_EN
   ,
   input  logic         stat_clr,
   output logic [15:0]  stat_default_cnt,
   output logic [15:0]  stat_explicit_cnt
`endif
);

   localparam logic [W-1:0] C_DEFAULT_B = W'(DEFAULT_B);

   logic         s1_valid_q, s1_valid_d;
   logic [W-1:0] s1_a_q,     s1_a_d;
   logic [W-1:0] s1_b_q,     s1_b_d;
   logic         s1_def_q,   s1_def_d;
   logic         s2_valid_q, s2_valid_d;
   logic [W:0]   s2_sum_q,   s2_sum_d;
   logic         s2_def_q,   s2_def_d;
   logic         s1_adv;
   logic         s2_adv;

   always_comb begin
      s2_adv   = s1_valid_q && (!s2_valid_q || out_ready);
      in_ready = !s1_valid_q || s2_adv;
      s1_adv   = in_valid && in_ready;

      s1_valid_d = s1_valid_q;
      s1_a_d     = s1_a_q;
      s1_b_d     = s1_b_q;
      s1_def_d   = s1_def_q;
      if (s1_adv) begin
         // b is resolved at capture so later in_b changes cannot leak in
         s1_valid_d = 1'b1;
         s1_a_d     = in_a;
         s1_b_d     = in_b_present ? in_b : C_DEFAULT_B;
         s1_def_d   = !in_b_present;
      end else if (s2_adv) begin
         s1_valid_d = 1'b0;
      end

      s2_valid_d = s2_valid_q;
      s2_sum_d   = s2_sum_q;
      s2_def_d   = s2_def_q;
      if (s2_adv) begin
         s2_valid_d = 1'b1;
         s2_sum_d   = {1'b0, s1_a_q} + {1'b0, s1_b_q};
         s2_def_d   = s1_def_q;
      end else if (out_ready) begin
         s2_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q <= 1'b0;
         s1_a_q     <= '0;
         s1_b_q     <= '0;
         s1_def_q   <= 1'b0;
         s2_valid_q <= 1'b0;
         s2_sum_q   <= '0;
         s2_def_q   <= 1'b0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s1_a_q     <= s1_a_d;
         s1_b_q     <= s1_b_d;
         s1_def_q   <= s1_def_d;
         s2_valid_q <= s2_valid_d;
         s2_sum_q   <= s2_sum_d;
         s2_def_q   <= s2_def_d;
      end
   end

   assign out_valid        = s2_valid_q;
   assign out_sum          = s2_sum_q;
   assign out_used_default = s2_def_q;

`ifdef OFFSET_ADD_STATS_EN
   logic        out_xfer;
   logic [15:0] def_cnt_q, def_cnt_d;
   logic [15:0] exp_cnt_q, exp_cnt_d;

   always_comb begin
      out_xfer  = s2_valid_q && out_ready;
      def_cnt_d = def_cnt_q;
      exp_cnt_d = exp_cnt_q;
      // clear wins over a same-cycle increment; counters stick at all-ones
      if (stat_clr) begin
         def_cnt_d = '0;
         exp_cnt_d = '0;
      end else if (out_xfer) begin
         if (s2_def_q) begin
            if (def_cnt_q != 16'hFFFF) def_cnt_d = def_cnt_q + 16'd1;
         end else begin
            if (exp_cnt_q != 16'hFFFF) exp_cnt_d = exp_cnt_q + 16'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         def_cnt_q <= '0;
         exp_cnt_q <= '0;
      end else begin
         def_cnt_q <= def_cnt_d;
         exp_cnt_q <= exp_cnt_d;
      end
   end

   assign stat_default_cnt  = def_cnt_q;
   assign stat_explicit_cnt = exp_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_offset_add_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_offset_add_stage
//  Purpose  : Directed self-checking bench for offset_add_stage (W=8,
//             DEFAULT_B=10). Counter checks compile with OFFSET_ADD_STATS_EN.
//  Revision : 1.0  initial release
// ============================================================================
module tb_offset_add_stage;

   logic       clk;
   logic       rst_n;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_a;
   logic [7:0] in_b;
   logic       in_b_present;
   logic       out_valid;
   logic       out_ready;
   logic [8:0] out_sum;
   logic       out_used_default;
`ifdef OFFSET_ADD_STATS_EN
   logic        stat_clr;
   logic [15:0] stat_default_cnt;
   logic [15:0] stat_explicit_cnt;
`endif

   int total;
   int bad;

   offset_add_stage #(.W(8), .DEFAULT_B(10)) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .in_valid         (in_valid),
      .in_ready         (in_ready),
      .in_a             (in_a),
      .in_b             (in_b),
      .in_b_present     (in_b_present),
      .out_valid        (out_valid),
      .out_ready        (out_ready),
      .out_sum          (out_sum),
      .out_used_default (out_used_default)
`ifdef OFFSET_ADD_STATS_EN
      ,
      .stat_clr         (stat_clr),
      .stat_default_cnt (stat_default_cnt),
      .stat_explicit_cnt(stat_explicit_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // inputs change 1 time unit after the rising edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [7:0] a, input logic [7:0] b, input logic bp);
      in_valid     = v;
      in_a         = a;
      in_b         = b;
      in_b_present = bp;
   endtask

   task automatic drain();
      in_valid  = 1'b0;
      out_ready = 1'b1;
      repeat (4) step();
   endtask

   task automatic test_reset();
      @(negedge clk);
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %0d expected 0", out_valid); end
      total++; if (out_sum !== 9'd0) begin bad++; $display("FAIL reset_out_sum: got %0d expected 0", out_sum); end
      total++; if (out_used_default !== 1'b0) begin bad++; $display("FAIL reset_used_default: got %0d expected 0", out_used_default); end
      step();
      rst_n = 1'b1;
      @(negedge clk);
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %0d expected 1", in_ready); end
      step();
   endtask

   task automatic test_default();
      out_ready = 1'b1;
      drive(1'b1, 8'd28, 8'd99, 1'b0);
      step();
      in_valid = 1'b0;
      @(negedge clk);
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL default_latency1: got out_valid=%0d expected 0", out_valid); end
      step();
      @(negedge clk);
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL default_valid: got %0d expected 1", out_valid); end
      total++; if (out_sum !== 9'd38) begin bad++; $display("FAIL default_sum: got %0d expected 38", out_sum); end
      total++; if (out_used_default !== 1'b1) begin bad++; $display("FAIL default_flag: got %0d expected 1", out_used_default); end
      step();
      @(negedge clk);
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL default_popped: got out_valid=%0d expected 0", out_valid); end
      drain();
   endtask

   task automatic test_max_and_zero();
      out_ready = 1'b1;
      drive(1'b1, 8'd255, 8'd255, 1'b1);
      step();
      drive(1'b1, 8'd0, 8'd200, 1'b0);
      step();
      in_valid = 1'b0;
      @(negedge clk);
      total++; if (out_sum !== 9'h1FE) begin bad++; $display("FAIL max_sum: got %0d expected 510", out_sum); end
      total++; if (out_used_default !== 1'b0) begin bad++; $display("FAIL max_flag: got %0d expected 0", out_used_default); end
      step();
      @(negedge clk);
      total++; if (out_valid !== 1'b1 || out_sum !== 9'd10) begin bad++; $display("FAIL zero_default_sum: got valid=%0d sum=%0d expected valid=1 sum=10", out_valid, out_sum); end
      total++; if (out_used_default !== 1'b1) begin bad++; $display("FAIL zero_default_flag: got %0d expected 1", out_used_default); end
      drain();
   endtask

   task automatic test_back_to_back();
      out_ready = 1'b1;
      for (int c = 0; c < 10; c++) begin
         if (c < 8) drive(1'b1, 8'(c), 8'(c), 1'b1);
         else       in_valid = 1'b0;
         @(negedge clk);
         if (c < 8) begin
            total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_in_ready[%0d]: got %0d expected 1", c, in_ready); end
         end
         if (c < 2) begin
            total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_fill[%0d]: got out_valid=%0d expected 0", c, out_valid); end
         end else begin
            total++;
            if (out_valid !== 1'b1 || out_sum !== 9'(2 * (c - 2))) begin
               bad++;
               $display("FAIL b2b_sum[%0d]: got valid=%0d sum=%0d expected valid=1 sum=%0d", c, out_valid, out_sum, 2 * (c - 2));
            end
         end
         step();
      end
      drain();
   endtask

   task automatic test_backpressure();
      out_ready = 1'b0;
      drive(1'b1, 8'd100, 8'd1, 1'b1);
      step();
      drive(1'b1, 8'd101, 8'd1, 1'b1);
      @(negedge clk);
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_second_accept: got in_ready=%0d expected 1", in_ready); end
      step();
      drive(1'b1, 8'd102, 8'd1, 1'b1);
      @(negedge clk);
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_full: got in_ready=%0d expected 0", in_ready); end
      total++; if (out_valid !== 1'b1 || out_sum !== 9'd101) begin bad++; $display("FAIL bp_hold1: got valid=%0d sum=%0d expected valid=1 sum=101", out_valid, out_sum); end
      step();
      in_a = 8'd7;
      @(negedge clk);
      total++; if (out_sum !== 9'd101 || in_ready !== 1'b0) begin bad++; $display("FAIL bp_hold2: got sum=%0d in_ready=%0d expected sum=101 in_ready=0", out_sum, in_ready); end
      step();
      drive(1'b1, 8'd102, 8'd1, 1'b1);
      out_ready = 1'b1;
      @(negedge clk);
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_release_ready: got %0d expected 1", in_ready); end
      step();
      in_valid = 1'b0;
      @(negedge clk);
      total++; if (out_valid !== 1'b1 || out_sum !== 9'd102) begin bad++; $display("FAIL bp_result2: got valid=%0d sum=%0d expected valid=1 sum=102", out_valid, out_sum); end
      step();
      @(negedge clk);
      total++; if (out_valid !== 1'b1 || out_sum !== 9'd103) begin bad++; $display("FAIL bp_result3: got valid=%0d sum=%0d expected valid=1 sum=103", out_valid, out_sum); end
      step();
      @(negedge clk);
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_no_extra: got out_valid=%0d expected 0", out_valid); end
      drain();
   endtask

   task automatic test_reset_mid();
      out_ready = 1'b0;
      drive(1'b1, 8'd5, 8'd5, 1'b1);
      step();
      drive(1'b1, 8'd6, 8'd6, 1'b1);
      step();
      in_valid = 1'b0;
      @(negedge clk);
      total++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin bad++; $display("FAIL rstmid_full: got in_ready=%0d out_valid=%0d expected 0/1", in_ready, out_valid); end
      step();
      rst_n = 1'b0;
      #1;
      total++; if (out_valid !== 1'b0 || out_sum !== 9'd0) begin bad++; $display("FAIL rstmid_flush: got valid=%0d sum=%0d expected 0/0", out_valid, out_sum); end
      step();
      rst_n = 1'b1;
      @(negedge clk);
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rstmid_in_ready: got %0d expected 1", in_ready); end
      step();
      out_ready = 1'b1;
      drive(1'b1, 8'd1, 8'd0, 1'b0);
      step();
      in_valid = 1'b0;
      step();
      @(negedge clk);
      total++; if (out_valid !== 1'b1 || out_sum !== 9'd11 || out_used_default !== 1'b1) begin bad++; $display("FAIL rstmid_next: got valid=%0d sum=%0d def=%0d expected 1/11/1", out_valid, out_sum, out_used_default); end
      step();
      @(negedge clk);
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rstmid_stale: got out_valid=%0d expected 0", out_valid); end
      drain();
   endtask

`ifdef OFFSET_ADD_STATS_EN
   task automatic test_stats();
      out_ready = 1'b1;
      stat_clr  = 1'b1;
      step();
      stat_clr  = 1'b0;
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, 8'(i + 1), 8'd3, (i >= 3) ? 1'b1 : 1'b0);
         step();
      end
      in_valid = 1'b0;
      repeat (3) step();
      @(negedge clk);
      total++; if (stat_default_cnt !== 16'd3) begin bad++; $display("FAIL stat_default: got %0d expected 3", stat_default_cnt); end
      total++; if (stat_explicit_cnt !== 16'd2) begin bad++; $display("FAIL stat_explicit: got %0d expected 2", stat_explicit_cnt); end
      step();
      drive(1'b1, 8'd9, 8'd0, 1'b0);
      step();
      in_valid = 1'b0;
      step();
      stat_clr = 1'b1;
      step();
      stat_clr = 1'b0;
      @(negedge clk);
      total++; if (stat_default_cnt !== 16'd0 || stat_explicit_cnt !== 16'd0) begin bad++; $display("FAIL stat_clr_pop: got def=%0d exp=%0d expected 0/0", stat_default_cnt, stat_explicit_cnt); end
      drain();
   endtask
`endif

   initial begin
      total        = 0;
      bad          = 0;
      rst_n        = 1'b0;
      in_valid     = 1'b0;
      in_a         = 8'd0;
      in_b         = 8'd0;
      in_b_present = 1'b0;
      out_ready    = 1'b1;
`ifdef OFFSET_ADD_STATS_EN
      stat_clr     = 1'b0;
`endif
      test_reset();
      test_default();
      test_max_and_zero();
      test_back_to_back();
      test_backpressure();
      test_reset_mid();
`ifdef OFFSET_ADD_STATS_EN
      test_stats();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
